dict_load_sequencer: RTL and testbench

//  Boot-time configurator for the code-compression front end. After reset (or on reload) it

---
 rtl/dict_load_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_dict_load_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dict_load_sequencer.sv
// Boot-time dictionary loader: fetches a header plus three dictionary
// images from memory, then hands the memory port to the controller.
module dict_load_sequencer #(
  parameter logic [31:0] DICT_BASE_ADDR = 32'h0000_1000,
  parameter int FIELD1_KEY_WIDTH = 3,
  parameter int FIELD2_KEY_WIDTH = 5,
  parameter int FIELD3_KEY_WIDTH = 8,
  parameter int FIELD1_VAL_WIDTH = 7,
  parameter int FIELD2_VAL_WIDTH = 10,
  parameter int FIELD3_VAL_WIDTH = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reload,
  output logic                        cpu_stall,
  output logic                        load_done,
  output logic                        load_err,
  output logic                        dict_clear,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  input  logic                        ctrl_mem_req_valid,
  output logic                        ctrl_mem_req_ready,
  input  logic [31:0]                 ctrl_mem_req_addr,
  output logic [31:0]                 ctrl_mem_req_rdata,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata
);

  localparam logic [9:0] C1_MAX = 10'(2 ** FIELD1_KEY_WIDTH);
  localparam logic [9:0] C2_MAX = 10'(2 ** FIELD2_KEY_WIDTH);
  localparam logic [9:0] C3_MAX = 10'(2 ** FIELD3_KEY_WIDTH);

  typedef enum logic [2:0] {
    S_CLEAR, S_HDR, S_D1, S_D2, S_D3, S_DONE
  } state_t;

  state_t      state;
  state_t      tgt;
  state_t      after_d1;
  state_t      after_d2;
  logic        req_valid;
  logic [31:0] ptr;
  logic [9:0]  c1;
  logic [9:0]  c2;
  logic [9:0]  c3;
  logic [9:0]  cnt;
  logic [9:0]  limit;
  logic        leave;
  logic [9:0]  h1;
  logic [9:0]  h2;
  logic [9:0]  h3;
  logic        over1;
  logic        over2;
  logic        over3;

  assign h1    = {6'd0, mem_req_rdata[3:0]};
  assign h2    = {4'd0, mem_req_rdata[9:4]};
  assign h3    = {1'b0, mem_req_rdata[18:10]};
  assign over1 = h1 > C1_MAX;
  assign over2 = h2 > C2_MAX;
  assign over3 = h3 > C3_MAX;

  // Empty dictionaries are skipped by chaining to the next non-empty one.
  always_comb begin
    after_d2 = (c3 != 10'd0) ? S_D3 : S_DONE;
    after_d1 = (c2 != 10'd0) ? S_D2 : after_d2;
    tgt      = S_DONE;
    limit    = '0;
    case (state)
      S_HDR: tgt = (c1 != 10'd0) ? S_D1 : after_d1;
      S_D1: begin
        tgt   = after_d1;
        limit = c1;
      end
      S_D2: begin
        tgt   = after_d2;
        limit = c2;
      end
      S_D3: begin
        tgt   = S_DONE;
        limit = c3;
      end
      default: ;
    endcase
  end

  assign leave = (state == S_HDR) || (cnt == limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_CLEAR;
      req_valid          <= 1'b0;
      ptr                <= '0;
      cnt                <= '0;
      c1                 <= '0;
      c2                 <= '0;
      c3                 <= '0;
      cpu_stall          <= 1'b1;
      load_done          <= 1'b0;
      load_err           <= 1'b0;
      dict_clear         <= 1'b0;
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      dict1_write_val    <= '0;
      dict2_write_val    <= '0;
      dict3_write_val    <= '0;
    end else begin
      dict_clear         <= 1'b0;
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      case (state)
        S_CLEAR: begin
          dict_clear <= 1'b1;
          load_err   <= 1'b0;
          ptr        <= DICT_BASE_ADDR;
          cnt        <= '0;
          req_valid  <= 1'b1;
          state      <= S_HDR;
        end
        S_HDR, S_D1, S_D2, S_D3: begin
          if (req_valid) begin
            if (mem_req_ready) begin
              req_valid <= 1'b0;
              ptr       <= ptr + 32'd4;
              cnt       <= cnt + 10'd1;
              case (state)
                S_HDR: begin
                  c1       <= over1 ? C1_MAX : h1;
                  c2       <= over2 ? C2_MAX : h2;
                  c3       <= over3 ? C3_MAX : h3;
                  load_err <= over1 | over2 | over3;
                end
                S_D1: begin
                  dict1_write_enable <= 1'b1;
                  dict1_write_val <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                end
                S_D2: begin
                  dict2_write_enable <= 1'b1;
                  dict2_write_val <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                end
                default: begin
                  dict3_write_enable <= 1'b1;
                  dict3_write_val <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                end
              endcase
            end
          end else if (leave) begin
            state     <= tgt;
            cnt       <= '0;
            req_valid <= (tgt != S_DONE);
            if (tgt == S_DONE) begin
              load_done <= 1'b1;
              cpu_stall <= 1'b0;
            end
          end else begin
            req_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (reload && !ctrl_mem_req_valid) begin
            state     <= S_CLEAR;
            load_done <= 1'b0;
            cpu_stall <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // After the load the controller owns the memory port.
  assign mem_req_valid = (state == S_DONE) ? ctrl_mem_req_valid : req_valid;
  assign mem_req_addr  = (state == S_DONE) ? ctrl_mem_req_addr : ptr;
  assign ctrl_mem_req_ready = mem_req_ready & load_done;
  assign ctrl_mem_req_rdata = mem_req_rdata;

endmodule

// File: tb/tb_dict_load_sequencer.sv
// Bench for dict_load_sequencer: memory model with random stalls and a
// reference built from the image layout rules.
module tb_dict_load_sequencer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, reload;
  logic        cpu_stall, load_done, load_err, dict_clear;
  logic        we1, we2, we3;
  logic [6:0]  val1;
  logic [9:0]  val2;
  logic [14:0] val3;
  logic        ctrl_valid, ctrl_ready;
  logic [31:0] ctrl_addr, ctrl_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_rdata;

  dict_load_sequencer dut (
    .clk(clk), .reset(reset), .reload(reload),
    .cpu_stall(cpu_stall), .load_done(load_done),
    .load_err(load_err), .dict_clear(dict_clear),
    .dict1_write_enable(we1), .dict1_write_val(val1),
    .dict2_write_enable(we2), .dict2_write_val(val2),
    .dict3_write_enable(we3), .dict3_write_val(val3),
    .ctrl_mem_req_valid(ctrl_valid),
    .ctrl_mem_req_ready(ctrl_ready),
    .ctrl_mem_req_addr(ctrl_addr),
    .ctrl_mem_req_rdata(ctrl_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_rdata(mem_req_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] img [0:299];
  int img_len = 1;
  int k1, k2, k3;
  int extra_max = 0;
  int wait_cnt = 1;
  int leak = 0;

  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] q3 [$];
  logic [31:0] qa [$];
  int qo [$];

  function automatic logic [31:0] lookup(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    if (idx < 32'(img_len)) return img[idx];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: ready 1 cycle after valid plus a random stall per request.
  always @(negedge clk) begin
    if (!mem_req_valid) begin
      mem_req_ready = 1'b0;
      wait_cnt = 1 + ((extra_max > 0) ? int'($urandom_range(0, extra_max)) : 0);
    end else if (wait_cnt == 0) begin
      mem_req_ready = 1'b1;
      mem_req_rdata = lookup(mem_req_addr);
    end else begin
      mem_req_ready = 1'b0;
      wait_cnt--;
    end
  end

  always @(posedge clk) begin
    if (reset || dict_clear) begin
      q1.delete(); q2.delete(); q3.delete();
      qa.delete(); qo.delete();
    end else begin
      if (we1) begin q1.push_back(32'(val1)); qo.push_back(1); end
      if (we2) begin q2.push_back(32'(val2)); qo.push_back(2); end
      if (we3) begin q3.push_back(32'(val3)); qo.push_back(3); end
      if (mem_req_valid && mem_req_ready && !load_done)
        qa.push_back(mem_req_addr);
      if (ctrl_ready && !load_done) leak++;
    end
  end

  task automatic build(input int h1, input int h2, input int h3);
    img[0] = 32'((h3 << 10) | (h2 << 4) | h1);
    k1 = (h1 > 8) ? 8 : h1;
    k2 = (h2 > 32) ? 32 : h2;
    k3 = (h3 > 256) ? 256 : h3;
    img_len = 1 + k1 + k2 + k3;
    for (int i = 1; i < 300; i++) img[i] = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!load_done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_in_time", load_done, 1'b1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic verify(input logic err);
    int idx;
    int inv;
    chk("n1", q1.size(), k1);
    chk("n2", q2.size(), k2);
    chk("n3", q3.size(), k3);
    idx = 1;
    for (int i = 0; i < k1; i++) begin
      if (i < q1.size()) chk("d1val", q1[i], img[idx] & 32'h7F);
      idx++;
    end
    for (int i = 0; i < k2; i++) begin
      if (i < q2.size()) chk("d2val", q2[i], img[idx] & 32'h3FF);
      idx++;
    end
    for (int i = 0; i < k3; i++) begin
      if (i < q3.size()) chk("d3val", q3[i], img[idx] & 32'h7FFF);
      idx++;
    end
    chk("naddr", qa.size(), img_len);
    for (int i = 0; i < img_len && i < qa.size(); i++)
      chk("addr", qa[i], BASE + 32'(4 * i));
    inv = 0;
    for (int i = 1; i < qo.size(); i++) if (qo[i] < qo[i-1]) inv++;
    chk("order", inv, 0);
    chk("load_err", load_err, err);
    chk("cpu_stall_done", cpu_stall, 1'b0);
  endtask

  initial begin
    int cyc;
    bit found;
    reset = 1'b1; reload = 1'b0;
    ctrl_valid = 1'b0; ctrl_addr = '0;
    mem_req_ready = 1'b0; mem_req_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", cpu_stall, 1'b1);
    chk("rst_done", load_done, 1'b0);
    chk("rst_err", load_err, 1'b0);
    chk("rst_clear", dict_clear, 1'b0);
    chk("rst_we", {29'd0, we1, we2, we3}, 32'd0);
    chk("rst_vals", {val1, val2, val3}, 32'd0);
    chk("rst_valid", mem_req_valid, 1'b0);
    chk("rst_addr", mem_req_addr, 32'd0);

    // 1: small image, fixed latency
    build(2, 1, 0);
    img[1] = 32'hABCD_0091;
    img[2] = 32'h0000_00A2;
    img[3] = 32'h1234_5555;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t1_clear", dict_clear, 1'b1);
    chk("t1_first_addr", mem_req_addr, BASE);
    wait_done(cyc);
    chk("t1_latency", cyc + 1, 13);
    verify(1'b0);
    chk("t1_v0", q1.size() > 0 ? q1[0] : 32'hX, 32'h11);
    chk("t1_v2", q2.size() > 0 ? q2[0] : 32'hX, 32'h155);

    // 2: empty header
    build(0, 0, 0);
    do_reload();
    chk("t2_clr_done", load_done, 1'b0);
    chk("t2_clr_stall", cpu_stall, 1'b1);
    wait_done(cyc);
    chk("t2_latency", cyc, 4);
    verify(1'b0);

    // 3: clamp, then reload with a sane header clears the error
    build(15, 0, 0);
    do_reload();
    wait_done(cyc);
    chk("t3_latency", cyc, 1 + 3 * 9);
    verify(1'b1);
    build(1, 1, 1);
    do_reload();
    @(posedge clk); #1;
    chk("t3_err_cleared", load_err, 1'b0);
    wait_done(cyc);
    verify(1'b0);

    // 5: pass-through in DONE; reload with ctrl_valid high is ignored
    ctrl_valid = 1'b1;
    ctrl_addr = 32'h200;
    reload = 1'b1;
    #1;
    chk("t5_valid", mem_req_valid, 1'b1);
    chk("t5_addr", mem_req_addr, 32'h200);
    @(negedge clk); #1;
    chk("t5_ready_wait", ctrl_ready, 1'b0);
    @(negedge clk); #1;
    chk("t5_ready", ctrl_ready, 1'b1);
    chk("t5_rdata", ctrl_rdata, lookup(32'h200));
    @(posedge clk); #1;
    chk("t5_reload_ignored", load_done, 1'b1);
    ctrl_valid = 1'b0;
    reload = 1'b0;
    @(posedge clk); #1;
    chk("t5_still_done", load_done, 1'b1);
    chk("t5_idle", mem_req_valid, 1'b0);

    // 4: reset while the 3rd dict2 word is pending
    build(2, 5, 0);
    do_reload();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_req_valid && mem_req_addr == BASE + 32'd20) found = 1;
    end
    chk("t4_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_valid_drop", mem_req_valid, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t4_clear", dict_clear, 1'b1);
    chk("t4_restart_addr", mem_req_addr, BASE);
    chk("t4_restart_valid", mem_req_valid, 1'b1);
    wait_done(cyc);
    chk("t4_latency", cyc + 1, 1 + 3 * 8);
    verify(1'b0);

    // 6: full image and random images under random stalls
    extra_max = 7;
    build(8, 32, 256);
    do_reload();
    wait_done(cyc);
    verify(1'b0);
    chk("t6_writes", q1.size() + q2.size() + q3.size(), 296);
    for (int r = 0; r < 3; r++) begin
      int a, b, c;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 63));
      c = int'($urandom_range(0, 300));
      build(a, b, c);
      do_reload();
      wait_done(cyc);
      verify(a > 8 || b > 32 || c > 256);
    end

    chk("ctrl_ready_leak", leak, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
